// File: rtl/brent_addsub_pipe.sv
// Two-stage pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Stage 1 registers the prefix-tree up-sweep; stage 2 registers the down-sweep result and flags.
module brent_addsub_pipe #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int LW = $clog2(W);

    // Up-sweep: node i at level l covers bits i-2^l+1..i when (i+1) is a multiple of 2^l.
    // Each index ends up holding the (G,P) of the largest group it roots.
    function automatic logic [2*W-1:0] up_sweep(input logic [W-1:0] g, input logic [W-1:0] p);
        logic [W-1:0]  gu;
        logic [W-1:0]  pu;
        logic [LW-1:0] hi;
        logic [LW-1:0] lo;
        gu = g;
        pu = p;
        for (int l = 1; l <= LW; l++) begin
            for (int i = 0; i < W; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    hi = LW'(i);
                    lo = LW'(i - (1 << (l - 1)));
                    gu[hi] = gu[hi] | (pu[hi] & gu[lo]);
                    pu[hi] = pu[hi] & pu[lo];
                end
            end
        end
        return {pu, gu};
    endfunction

    // Down-sweep: fills the prefixes the up-sweep left incomplete, widest span first.
    // Returns carries c[0..W]; c[0] is the carry-in, c[i+1] is the carry out of bit i.
    function automatic logic [W:0] carries(input logic [W-1:0] gu, input logic [W-1:0] pu,
                                           input logic cin);
        logic [W-1:0]  gd;
        logic [LW-1:0] hi;
        logic [LW-1:0] lo;
        int            idx;
        gd = gu;
        for (int l = LW - 1; l >= 1; l--) begin
            for (int m = 1; m < W; m++) begin
                idx = m * (1 << l) + (1 << (l - 1)) - 1;
                if (idx < W) begin
                    hi = LW'(idx);
                    lo = LW'(idx - (1 << (l - 1)));
                    gd[hi] = gd[hi] | (pu[hi] & gd[lo]);
                end
            end
        end
        return {gd, cin};
    endfunction

    logic         adv1;
    logic         adv2;

    logic         vld_p1;
    logic [W-1:0] p_p1;
    logic [W-1:0] gu_p1;
    logic [W-1:0] pu_p1;
    logic         cin_p1;
    logic         amsb_p1;
    logic         bmsb_p1;

    logic         vld_p2;
    logic [W-1:0] sum_p2;
    logic         cout_p2;
    logic         ovf_p2;
    logic         zero_p2;

    logic [W-1:0] beff;
    logic [W-1:0] g_bit;
    logic [W-1:0] p_bit;
    logic [W-1:0] g_fold;
    logic [W-1:0] gu_d;
    logic [W-1:0] pu_d;

    logic [W:0]   c_d;
    logic [W-1:0] sum_d;
    logic         ovf_d;

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    // Stage 1 input: operand conditioning, carry-in folded into bit 0 as a virtual bit -1.
    always_comb begin
        beff      = sub ? ~B : B;
        g_bit     = A & beff;
        p_bit     = A ^ beff;
        g_fold    = g_bit;
        g_fold[0] = g_bit[0] | (p_bit[0] & sub);
        {pu_d, gu_d} = up_sweep(g_fold, p_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1) begin
            p_p1    <= p_bit;
            gu_p1   <= gu_d;
            pu_p1   <= pu_d;
            cin_p1  <= sub;
            amsb_p1 <= A[W-1];
            bmsb_p1 <= beff[W-1];
        end
    end

    // Stage 2 input: carries, sum and flags.
    always_comb begin
        c_d   = carries(gu_p1, pu_p1, cin_p1);
        sum_d = p_p1 ^ c_d[W-1:0];
        ovf_d = (amsb_p1 == bmsb_p1) && (sum_d[W-1] != amsb_p1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2  <= vld_p1;
            sum_p2  <= sum_d;
            cout_p2 <= c_d[W];
            ovf_p2  <= ovf_d;
            zero_p2 <= (sum_d == '0);
        end
    end

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign cout      = cout_p2;
    assign ovf       = ovf_p2;
    assign zero      = zero_p2;

endmodule

// File: tb/tb_brent_addsub_pipe.sv
// Scoreboard bench for brent_addsub_pipe: directed vectors, backpressure, mid-flight reset, random traffic.
module tb_brent_addsub_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W+2:0] sb_q[$];
    logic         stall_prev = 1'b0;
    logic [W+2:0] out_prev = '0;

    brent_addsub_pipe #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference built from integer arithmetic: {sum, cout, ovf, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        longint       ua, ub, sa, sbv, r, sr;
        logic [W-1:0] res;
        logic         c, v;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (s) begin
            r  = ua - ub;
            sr = sa - sbv;
            c  = (ua >= ub);
        end else begin
            r  = ua + ub;
            sr = sa + sbv;
            c  = (r >= (longint'(1) << W));
        end
        res = r[W-1:0];
        v   = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        return {res, c, v, (res == '0)};
    endfunction

    // One cycle: drive at the falling edge, then observe the handshakes the next rising edge will act on.
    task automatic step(input logic rst, input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input logic ordy,
                        output logic acc);
        logic [W+2:0] got;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        A         = a;
        B         = b;
        sub       = s;
        out_ready = ordy;
        #1;
        got = {sum, cout, ovf, zero};
        acc = 1'b0;
        if (!reset) begin
            if (stall_prev)
                chk("stall_hold", 32'({out_valid, got}), 32'({1'b1, out_prev}));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    chk("out_unexpected", 32'(out_valid), 32'(0));
                else
                    chk("result", 32'(got), 32'(sb_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, s));
                acc = 1'b1;
            end
        end
        stall_prev = !reset && out_valid && !out_ready;
        out_prev   = got;
    endtask

    logic [W-1:0] ta[7] = '{16'd32767, 16'd65535, 16'd1024, 16'd16, 16'd4, 16'd32768, 16'd5};
    logic [W-1:0] tb[7] = '{16'd64, 16'd1, 16'd32767, 16'd4, 16'd16, 16'd1, 16'd5};
    logic         ts[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Expected {sum, cout, ovf, zero} for the directed table.
    logic [W+2:0] te[7] = '{{16'd32831, 3'b010}, {16'd0, 3'b101}, {16'd33791, 3'b010},
                            {16'd12, 3'b100}, {16'd65524, 3'b000}, {16'd32767, 3'b110},
                            {16'd0, 3'b101}};

    initial begin
        logic         acc;
        int           idx;
        int           acc_n;
        logic         pend;
        logic         iv;
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [W-1:0] edge_vals[4];

        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        chk("rst_outputs", 32'({out_valid, sum, cout, ovf, zero}), 32'(0));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));

        // Single beat 0+0: visible two cycles later for exactly one cycle.
        step(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, acc);
        chk("t1_accept", 32'(acc), 32'(1));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("t1_lat1", 32'(out_valid), 32'(0));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("t1_lat2", 32'(out_valid), 32'(1));
        chk("t1_res", 32'({sum, cout, ovf, zero}), 32'({16'd0, 3'b001}));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("t1_once", 32'(out_valid), 32'(0));

        // Back-to-back adds then subtracts, results on consecutive cycles.
        for (int k = 0; k < 9; k++) begin
            if (k < 7) step(1'b0, 1'b1, ta[k], tb[k], ts[k], 1'b1, acc);
            else       step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (k < 7) chk("dir_accept", 32'(acc), 32'(1));
            if (k >= 2) begin
                chk("dir_valid", 32'(out_valid), 32'(1));
                chk("dir_res", 32'({sum, cout, ovf, zero}), 32'(te[k-2]));
            end
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("dir_end", 32'(out_valid), 32'(0));

        // Backpressure: consumer stalls for 5 cycles while 4 beats are offered.
        edge_vals = '{16'h0000, 16'hffff, 16'h8000, 16'h7fff};
        idx = 0;
        for (int c = 0; c < 40 && (idx < 4 || sb_q.size() > 0); c++) begin
            if (idx < 4) step(1'b0, 1'b1, edge_vals[idx], 16'h0001, 1'(idx & 1), c >= 5, acc);
            else         step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (acc) idx++;
            if (c == 2) chk("bp_in_ready", 32'(in_ready), 32'(0));
            if (c == 4) chk("bp_in_flight", 32'(idx), 32'(2));
        end
        chk("bp_drained", 32'(sb_q.size()), 32'(0));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("bp_no_dup", 32'(out_valid), 32'(0));

        // Reset with two beats in flight.
        step(1'b0, 1'b1, 16'd1000, 16'd1, 1'b0, 1'b0, acc);
        chk("rm_acc1", 32'(acc), 32'(1));
        step(1'b0, 1'b1, 16'd2000, 16'd3, 1'b1, 1'b0, acc);
        chk("rm_acc2", 32'(acc), 32'(1));
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
        sb_q.delete();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rm_out_valid", 32'(out_valid), 32'(0));
        chk("rm_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
            chk("rm_flushed", 32'(out_valid), 32'(0));
        end
        step(1'b0, 1'b1, 16'd256, 16'd32, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rm_next", 32'({out_valid, sum}), 32'({1'b1, 16'd288}));

        // Random traffic; the source holds an offered beat until it is taken.
        acc_n = 0;
        pend  = 1'b0;
        ra = '0; rb = '0; rs = 1'b0;
        for (int c = 0; c < 40000 && acc_n < 10000; c++) begin
            if (!pend) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) ra = edge_vals[$urandom_range(0, 3)];
                if ($urandom_range(0, 7) == 0) rb = edge_vals[$urandom_range(0, 3)];
                iv = ($urandom_range(0, 3) != 0);
            end else begin
                iv = 1'b1;
            end
            step(1'b0, iv, ra, rb, rs, $urandom_range(0, 3) != 0, acc);
            if (acc) acc_n++;
            pend = iv && !acc;
        end
        chk("rnd_count", 32'(acc_n), 32'(10000));
        for (int c = 0; c < 10 && sb_q.size() > 0; c++)
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rnd_drained", 32'(sb_q.size()), 32'(0));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rnd_idle", 32'(out_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
